// File: rtl/output_deskew_buffer.sv
// Re-aligns skewed per-column partial sums from the systolic array into whole rows,
// with per-column FIFOs, a single valid/ready output, per-tile row counting and flow-control flags.
module output_deskew_buffer #(
    parameter int SYS_COLS   = 4,
    parameter int P_BITWIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int CNT_W      = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [SYS_COLS-1:0]                  i_valid,
    input  logic [SYS_COLS-1:0][P_BITWIDTH-1:0]  i_data,
    output logic                                 o_valid,
    output logic [SYS_COLS-1:0][P_BITWIDTH-1:0]  o_data,
    input  logic                                 o_ready,
    input  logic [CNT_W-1:0]                     tile_rows,
    output logic                                 tile_done,
    output logic                                 o_stall,
    output logic                                 overflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] STALL_CNT = CW'(DEPTH - SYS_COLS);

    logic [SYS_COLS-1:0] push;
    logic [SYS_COLS-1:0] drop;
    logic [SYS_COLS-1:0] nonempty;
    logic [SYS_COLS-1:0] near_full;
    logic                pop;

    logic             o_valid_reg, o_valid_next;
    logic             overflow_reg, overflow_next;
    logic             tile_done_reg, tile_done_next;
    logic [CNT_W-1:0] row_cnt_reg, row_cnt_next;
    logic             handshake;

    // Pop only sees counts from before this edge; a same-edge push is not counted.
    assign pop       = (&nonempty) && (!o_valid_reg || o_ready);
    assign handshake = o_valid_reg && o_ready;

    generate
        for (genvar gi = 0; gi < SYS_COLS; gi++) begin : g_col
            logic [P_BITWIDTH-1:0] mem [DEPTH];
            logic [AW-1:0]         wr_ptr_reg;
            logic [AW-1:0]         rd_ptr_reg;
            logic [CW-1:0]         count_reg;
            logic [CW-1:0]         count_next;
            logic [P_BITWIDTH-1:0] out_reg;

            assign push[gi]      = i_valid[gi] && ((count_reg != FULL_CNT) || pop);
            assign drop[gi]      = i_valid[gi] && (count_reg == FULL_CNT) && !pop;
            assign nonempty[gi]  = (count_reg != '0);
            assign near_full[gi] = (count_reg >= STALL_CNT);

            always_comb begin
                count_next = count_reg;
                case ({push[gi], pop})
                    2'b10:   count_next = count_reg + 1'b1;
                    2'b01:   count_next = count_reg - 1'b1;
                    default: count_next = count_reg;
                endcase
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (push[gi]) wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    if (pop)      rd_ptr_reg <= rd_ptr_reg + 1'b1;
                    count_reg <= count_next;
                end
            end

            // Storage and output data carry no reset; both are qualified by counts/o_valid.
            always_ff @(posedge clk) begin
                if (push[gi] && !rst) mem[wr_ptr_reg] <= i_data[gi];
                if (pop && !rst)      out_reg <= mem[rd_ptr_reg];
            end

            assign o_data[gi] = out_reg;
        end
    endgenerate

    always_comb begin
        o_valid_next   = o_valid_reg;
        overflow_next  = overflow_reg || (|drop);
        tile_done_next = 1'b0;
        row_cnt_next   = row_cnt_reg;

        if (pop)
            o_valid_next = 1'b1;
        else if (o_ready)
            o_valid_next = 1'b0;

        // tile_rows == 0 disables the compare so the counter simply wraps.
        if (handshake) begin
            if ((tile_rows != '0) && (row_cnt_reg == tile_rows - 1'b1)) begin
                row_cnt_next   = '0;
                tile_done_next = 1'b1;
            end else begin
                row_cnt_next = row_cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid_reg   <= 1'b0;
            overflow_reg  <= 1'b0;
            tile_done_reg <= 1'b0;
            row_cnt_reg   <= '0;
        end else begin
            o_valid_reg   <= o_valid_next;
            overflow_reg  <= overflow_next;
            tile_done_reg <= tile_done_next;
            row_cnt_reg   <= row_cnt_next;
        end
    end

    assign o_valid   = o_valid_reg;
    assign overflow  = overflow_reg;
    assign tile_done = tile_done_reg;
    assign o_stall   = |near_full;

endmodule

// File: tb/tb_output_deskew_buffer.sv
// Directed bench for output_deskew_buffer (SYS_COLS=4, DEPTH=8, P_BITWIDTH=32).
// Inputs change 1 ns after each rising edge; outputs are checked at the same point.
module tb_output_deskew_buffer;

    logic             clk;
    logic             rst;
    logic [3:0]       i_valid;
    logic [3:0][31:0] i_data;
    logic             o_valid;
    logic [3:0][31:0] o_data;
    logic             o_ready;
    logic [15:0]      tile_rows;
    logic             tile_done;
    logic             o_stall;
    logic             overflow;

    int n_checks = 0;
    int n_fail   = 0;

    output_deskew_buffer #(
        .SYS_COLS  (4),
        .P_BITWIDTH(32),
        .DEPTH     (8),
        .CNT_W     (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_valid  (i_valid),
        .i_data   (i_data),
        .o_valid  (o_valid),
        .o_data   (o_data),
        .o_ready  (o_ready),
        .tile_rows(tile_rows),
        .tile_done(tile_done),
        .o_stall  (o_stall),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rowv(input int base, input int r);
        logic [127:0] v;
        v = '0;
        for (int c = 0; c < 4; c++) v[c*32 +: 32] = 32'(base + 16*r + c);
        return v;
    endfunction

    task automatic do_reset();
        rst     = 1'b1;
        i_valid = '0;
        tick();
        rst = 1'b0;
    endtask

    // Skewed stream of n rows with o_ready held high; checks every cycle.
    task automatic run_stream(input string tag, input int base, input int n, input int tdone_at);
        logic [3:0]       iv;
        logic [3:0][31:0] id;
        logic             ev;
        for (int t = 0; t < n + 6; t++) begin
            iv = '0;
            id = '0;
            for (int c = 0; c < 4; c++) begin
                if ((t - c) >= 0 && (t - c) < n) begin
                    iv[c] = 1'b1;
                    id[c] = 32'(base + 16*(t - c) + c);
                end
            end
            i_valid = iv;
            i_data  = id;
            tick();
            ev = (t >= 4) && (t - 4 < n);
            chk({tag, "_valid"}, 128'(o_valid), 128'(ev));
            if (ev) chk({tag, "_data"}, 128'(o_data), rowv(base, t - 4));
            chk({tag, "_tile_done"}, 128'(tile_done), 128'(t == tdone_at));
            $display("%s t=%0d o_valid=%0b o_data=%h tile_done=%0b", tag, t, o_valid, o_data, tile_done);
        end
        i_valid = '0;
    endtask

    initial begin
        rst       = 1'b1;
        i_valid   = '0;
        i_data    = '0;
        o_ready   = 1'b1;
        tile_rows = 16'd0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_valid", 128'(o_valid), 128'(0));
        chk("rst_tile_done", 128'(tile_done), 128'(0));
        chk("rst_stall", 128'(o_stall), 128'(0));
        chk("rst_overflow", 128'(overflow), 128'(0));

        // 1: single skewed row after 10 idle cycles
        for (int i = 0; i < 10; i++) tick();
        run_stream("single", 32'h100, 1, -1);

        // 2: six-row tile streamed at full rate
        do_reset();
        tile_rows = 16'd6;
        run_stream("stream6", 0, 6, 10);

        // 3: back-pressure while five rows arrive
        do_reset();
        tile_rows = 16'd0;
        o_ready   = 1'b0;
        for (int t = 0; t < 8; t++) begin
            i_valid = '0;
            i_data  = '0;
            for (int c = 0; c < 4; c++) begin
                if ((t - c) >= 0 && (t - c) < 5) begin
                    i_valid[c] = 1'b1;
                    i_data[c]  = 32'(32'h300 + 16*(t - c) + c);
                end
            end
            tick();
            chk("bp_stall", 128'(o_stall), 128'(t >= 3));
            chk("bp_valid", 128'(o_valid), 128'(t >= 4));
            if (t >= 4) chk("bp_hold", 128'(o_data), rowv(32'h300, 0));
            $display("bp t=%0d o_valid=%0b o_stall=%0b o_data=%h", t, o_valid, o_stall, o_data);
        end
        i_valid = '0;
        tick();
        tick();
        chk("bp_hold_idle", 128'(o_data), rowv(32'h300, 0));
        o_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("bp_rel_valid", 128'(o_valid), 128'(k <= 4));
            if (k <= 4) chk("bp_rel_data", 128'(o_data), rowv(32'h300, k));
            $display("bp_release k=%0d o_valid=%0b o_data=%h", k, o_valid, o_data);
        end

        // 4: overflow on column 0
        do_reset();
        o_ready = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            i_valid   = 4'b0001;
            i_data[0] = 32'(32'h400 + k);
            tick();
            chk("ovf_flag", 128'(overflow), 128'(k == 9));
            chk("ovf_valid", 128'(o_valid), 128'(0));
            $display("ovf push=%0d overflow=%0b o_stall=%0b", k, overflow, o_stall);
        end
        i_valid = '0;
        tick();
        tick();
        chk("ovf_sticky", 128'(overflow), 128'(1));
        do_reset();
        chk("ovf_rst_clear", 128'(overflow), 128'(0));
        $display("ovf after rst overflow=%0b", overflow);

        // 5: fill to full, then push and pop on the same edge
        o_ready = 1'b0;
        for (int r = 0; r < 9; r++) begin
            i_valid = 4'b1111;
            for (int c = 0; c < 4; c++) i_data[c] = 32'(32'h500 + 16*r + c);
            tick();
        end
        chk("full_pre_data", 128'(o_data), rowv(32'h500, 0));
        chk("full_pre_stall", 128'(o_stall), 128'(1));
        o_ready = 1'b1;
        for (int c = 0; c < 4; c++) i_data[c] = 32'(32'h500 + 16*9 + c);
        tick();
        i_valid = '0;
        chk("full_pp_overflow", 128'(overflow), 128'(0));
        chk("full_pp_valid", 128'(o_valid), 128'(1));
        chk("full_pp_data", 128'(o_data), rowv(32'h500, 1));
        $display("full push+pop o_data=%h overflow=%0b", o_data, overflow);
        for (int k = 2; k <= 10; k++) begin
            tick();
            chk("full_drain_valid", 128'(o_valid), 128'(k <= 9));
            if (k <= 9) chk("full_drain_data", 128'(o_data), rowv(32'h500, k));
            $display("full drain k=%0d o_valid=%0b o_data=%h", k, o_valid, o_data);
        end
        chk("full_end_overflow", 128'(overflow), 128'(0));

        // 6: reset after three rows of a six-row tile
        do_reset();
        tile_rows = 16'd6;
        o_ready   = 1'b1;
        for (int t = 0; t < 9; t++) begin
            i_valid = '0;
            i_data  = '0;
            for (int c = 0; c < 4; c++) begin
                if ((t - c) >= 0 && (t - c) < 6) begin
                    i_valid[c] = 1'b1;
                    i_data[c]  = 32'(32'h700 + 16*(t - c) + c);
                end
            end
            if (t == 8) rst = 1'b1;
            tick();
        end
        rst     = 1'b0;
        i_valid = '0;
        chk("midrst_valid", 128'(o_valid), 128'(0));
        chk("midrst_stall", 128'(o_stall), 128'(0));
        chk("midrst_tile_done", 128'(tile_done), 128'(0));
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("midrst_idle_valid", 128'(o_valid), 128'(0));
        end
        $display("midrst o_valid=%0b o_stall=%0b", o_valid, o_stall);
        run_stream("after_rst", 32'h600, 6, 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/output_deskew_buffer.md
Name: output_deskew_buffer

Overview:
- Sits directly downstream of the systolic array and consumes its per-column partial-sum outputs.
- Column c of the array produces row r one cycle after column c-1, because valids are skewed the same way the input side skews them.
- The block stores each column in its own FIFO and re-aligns columns into whole output rows.
- It emits each row on a single valid/ready interface, counts emitted rows per tile, and reports back-pressure and overflow to the controller.

Parameters:
- SYS_COLS, 4: number of systolic array columns.
- P_BITWIDTH, 32: width of one partial sum.
- DEPTH, 8: entries per column FIFO; must be a power of 2 and >= SYS_COLS+1.
- CNT_W, 16: width of the tile row counter and the tile_rows port.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- i_valid  in  SYS_COLS  per-column valid from the array (skewed).
- i_data  in  SYS_COLS x P_BITWIDTH  per-column partial sum.
- o_valid  out  1  aligned output row valid.
- o_data  out  SYS_COLS x P_BITWIDTH  aligned output row; element c comes from column c.
- o_ready  in  1  downstream accepts the row.
- tile_rows  in  CNT_W  rows per tile; sampled when each row handshake completes.
- tile_done  out  1  one-cycle pulse after the last row of a tile is accepted.
- o_stall  out  1  almost-full warning to the array controller.
- overflow  out  1  sticky error flag.

Behaviour:
- Reset (rst=1 at an edge):
  - Clears all FIFO read/write pointers and counts, o_valid, tile_done, overflow and the row counter.
  - FIFO storage and o_data are not cleared; o_data is don't-care while o_valid=0.
  - Reset mid-operation discards all buffered and in-flight rows. Inputs arriving during the reset cycle are ignored.
- Column FIFO c, push:
  - Pushes i_data[c] when i_valid[c]=1 and (count_c<DEPTH or a pop happens on the same edge).
  - Pointers wrap modulo DEPTH.
  - A push to a full FIFO with no same-edge pop is dropped, and overflow goes to 1 and stays 1 until rst.
- Pop condition (all FIFOs together):
  - pop = (every count_c>0) and (o_valid=0 or o_ready=1).
  - On pop: o_data[c] <= head_c for every c, o_valid <= 1, and every count decrements, unless the same column pushes on that edge.
- Output register:
  - If o_valid=1, o_ready=1 and no pop, then o_valid <= 0.
  - If o_valid=1 and o_ready=0, o_valid and o_data hold unchanged.
- Latency: the last column's element of a row is pushed at edge k. If the output register is free, o_valid=1 with that row after edge k+1. Sustained throughput is 1 row/cycle with o_ready held high.
- Simultaneous push and pop on the same column is legal at any count, including full and empty-to-nonempty. The push is not visible to the pop decision until the following cycle.
- o_stall is combinational: 1 when any count_c >= DEPTH-SYS_COLS. This leaves room for the rows already in flight in the skew pipeline.
- Row counter:
  - Increments on each handshake (o_valid and o_ready).
  - On the handshake where counter = tile_rows-1, the counter goes to 0 and tile_done=1 for exactly the next cycle.
  - tile_rows=0 means tile_done never asserts; the counter wraps at 2^CNT_W.
  - Changing tile_rows mid-tile takes effect at the next compare.
- Columns are never reordered. Rows exit in the order they entered.

Test Plan (SYS_COLS=4, DEPTH=8, P_BITWIDTH=32):
1. Skewed single row: column c valid at cycle 10+c with data 0x100+c, o_ready=1.
   - Required: o_valid=1 only in cycle 14, o_data={0x103,0x102,0x101,0x100}.
   - Required: o_valid=0 in cycle 15.
2. Streaming 6 rows (data = 16*row + col), skewed, o_ready=1, tile_rows=6.
   - Required: o_valid high for 6 consecutive cycles, rows in order.
   - Required: tile_done pulses once, the cycle after the 6th handshake.
3. Back-pressure: o_ready=0 while streaming 5 rows.
   - Required: first row held stable on o_data.
   - Required: o_stall rises once any count reaches 4.
   - Release o_ready: all 5 rows delivered in order, no gaps.
4. Overflow: o_ready=0, push 9 rows of column 0 only.
   - Required: 9th push dropped, overflow=1 the cycle after and sticky.
   - Required: rst clears overflow to 0.
5. Full with simultaneous push/pop: all columns at count 8, o_ready=1, new aligned row pushed on the pop edge.
   - Required: no overflow, counts stay 8, the popped row is the oldest.
6. Reset mid-tile: after 3 of 6 rows, assert rst for 1 cycle.
   - Required: o_valid=0, counts 0, tile_done not asserted for the first 5 rows of the next tile.
   - Required: the next tile's 6th handshake pulses tile_done.
